// File: rtl/prbs_bit_tx_if.sv
// Serial stream interface for the PRBS transmitter: one data bit with a
// valid/ready handshake. The transmitter drives O/O_valid, the link drives O_ready.
interface prbs_bit_tx_if;
   logic O;
   logic O_valid;
   logic O_ready;

   modport master (
      output O,
      output O_valid,
      input  O_ready
   );

   modport slave (
      input  O,
      input  O_valid,
      output O_ready
   );
endinterface : prbs_bit_tx_if

// File: rtl/prbs_bit_tx.sv
// PRBS bit transmitter: emits a seeded Fibonacci LFSR stream, one bit per
// valid/ready transfer, for a programmable number of bits per burst. A single
// pending error flag inverts exactly one transmitted bit without disturbing
// the sequence, so the far-end checker sees one isolated mismatch.
module prbs_bit_tx #(
   parameter int unsigned     WIDTH     = 7,
   parameter int unsigned     TAP_A     = 7,
   parameter int unsigned     TAP_B     = 6,
   parameter logic [WIDTH-1:0] SEED     = 7'h7F,
   parameter int unsigned     LEN_WIDTH = 16
) (
   input  logic                 CLK,
   input  logic                 ASYNCRESETN,
   input  logic                 start,
   input  logic [LEN_WIDTH-1:0] len,
   input  logic                 inject_err,
   output logic                 busy,
   output logic                 done,
   prbs_bit_tx_if.master        tx
);

   // An all-zero LFSR would lock up, so a zero seed is replaced by all-ones.
   localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? '1 : SEED;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     lfsr_q, lfsr_d;
   logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
   logic                 err_pend_q, err_pend_d;
   logic                 valid;
   logic                 xfer;
   logic                 feedback;

   assign feedback = lfsr_q[TAP_A-1] ^ lfsr_q[TAP_B-1];
   assign xfer     = valid & tx.O_ready;

   // Burst control: next state, LFSR/counter update, status outputs.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d = state_q;
      lfsr_d  = lfsr_q;
      cnt_d   = cnt_q;
      valid   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (len != '0) begin
                  lfsr_d  = SEED_EFF;
                  cnt_d   = len;
                  state_d = S_RUN;
               end else begin
                  // Zero-length burst: report completion without emitting bits.
                  state_d = S_DONE;
               end
            end
         end

         S_RUN: begin
            valid = 1'b1;
            busy  = 1'b1;
            // Everything advances only on an accepted bit, so a stall holds O steady.
            if (tx.O_ready) begin
               lfsr_d = {lfsr_q[WIDTH-2:0], feedback};
               cnt_d  = cnt_q - LEN_WIDTH'(1);
               if (cnt_q == LEN_WIDTH'(1)) begin
                  state_d = S_DONE;
               end
            end
         end

         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Error flag: a transfer consumes the pending error; a new request re-arms
   // it, so a request arriving with a transfer applies to the following bit.
   always_comb begin
      err_pend_d = (err_pend_q & ~xfer) | inject_err;
   end

   assign tx.O_valid = valid;
   assign tx.O       = valid & (lfsr_q[WIDTH-1] ^ err_pend_q);

   // State registers with asynchronous clear.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         state_q    <= S_IDLE;
         lfsr_q     <= SEED_EFF;
         cnt_q      <= '0;
         err_pend_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         cnt_q      <= cnt_d;
         err_pend_q <= err_pend_d;
      end
   end

endmodule : prbs_bit_tx

// File: tb/tb_prbs_bit_tx.sv
// Self-checking bench for prbs_bit_tx. Stimulus pushes expected bits into a
// scoreboard queue; a monitor pops and compares on every accepted transfer.
module tb_prbs_bit_tx;

   typedef struct {
      logic exp_bit;   // bit the link must carry (includes injected errors)
      logic ref_bit;   // bit of the clean reference sequence
   } sb_t;

   logic        CLK         = 1'b0;
   logic        ASYNCRESETN = 1'b0;
   logic        start       = 1'b0;
   logic [15:0] len         = '0;
   logic        inject_err  = 1'b0;
   logic        busy;
   logic        done;

   prbs_bit_tx_if tx_if ();

   prbs_bit_tx dut (
      .CLK         (CLK),
      .ASYNCRESETN (ASYNCRESETN),
      .start       (start),
      .len         (len),
      .inject_err  (inject_err),
      .busy        (busy),
      .done        (done),
      .tx          (tx_if)
   );

   always #5 CLK = ~CLK;

   int   n_checks  = 0;
   int   n_pass    = 0;
   sb_t  sb[$];

   // Monitor-owned statistics; stimulus only reads them as deltas.
   int   done_seen  = 0;
   int   busy_seen  = 0;
   int   valid_seen = 0;
   int   xnor_mism  = 0;
   logic stall_hold = 1'b0;
   logic held_o     = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic push(input logic e, input logic r);
      sb_t s;
      s.exp_bit = e;
      s.ref_bit = r;
      sb.push_back(s);
   endtask

   task automatic start_burst(input logic [15:0] l);
      start = 1'b1;
      len   = l;
      step();
      start = 1'b0;
      len   = '0;
   endtask

   task automatic wait_done(input string name, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge CLK);
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      check(name, int'(seen), 1);
      step();
   endtask

   // Monitor: sample away from the rising edge and score accepted bits.
   initial begin
      sb_t e;
      forever begin
         @(negedge CLK);
         if (!ASYNCRESETN) begin
            stall_hold = 1'b0;
         end else begin
            if (done === 1'b1) done_seen++;
            if (busy === 1'b1) busy_seen++;
            if (tx_if.O_valid === 1'b1) valid_seen++;
            if (stall_hold) begin
               check("stall_valid", int'(tx_if.O_valid), 1);
               check("stall_data", int'(tx_if.O), int'(held_o));
            end
            if (tx_if.O_valid === 1'b1 && tx_if.O_ready === 1'b1) begin
               stall_hold = 1'b0;
               if (sb.size() == 0) begin
                  check("unexpected_bit", 1, 0);
               end else begin
                  e = sb.pop_front();
                  check("bit", int'(tx_if.O), int'(e.exp_bit));
                  if (tx_if.O !== e.ref_bit) xnor_mism++;
               end
            end else if (tx_if.O_valid === 1'b1) begin
               stall_hold = 1'b1;
               held_o     = tx_if.O;
            end else begin
               stall_hold = 1'b0;
            end
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Directed stimulus.
   initial begin
      int           d0, b0, v0, x0;
      logic [6:0]   r;
      logic [7:0]   bits8;
      logic [5:0]   rdy_pat;

      tx_if.O_ready = 1'b0;

      // 1. Reset asserted, no clock edge yet: all outputs low.
      #2;
      check("rst_O", int'(tx_if.O), 0);
      check("rst_valid", int'(tx_if.O_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      @(negedge CLK);
      ASYNCRESETN = 1'b1;
      step();

      // 2. len=8, always ready: 1,1,1,1,1,1,1,0 then a single done pulse.
      bits8 = 8'b1111_1110;
      for (int i = 7; i >= 0; i--) push(bits8[i], bits8[i]);
      d0 = done_seen; b0 = busy_seen;
      tx_if.O_ready = 1'b1;
      start_burst(16'd8);
      wait_done("t2_done", 40);
      step();
      check("t2_done_count", done_seen - d0, 1);
      check("t2_busy_cycles", busy_seen - b0, 8);
      check("t2_sb_empty", sb.size(), 0);

      // 3. len=3 with ready pattern 1,0,0,1,0,1: stalls hold O, 3 transfers.
      push(1'b1, 1'b1); push(1'b1, 1'b1); push(1'b1, 1'b1);
      rdy_pat = 6'b101001;   // applied LSB first
      d0 = done_seen; b0 = busy_seen;
      start_burst(16'd3);
      for (int i = 0; i < 6; i++) begin
         tx_if.O_ready = rdy_pat[i];
         step();
      end
      tx_if.O_ready = 1'b1;
      wait_done("t3_done", 10);
      check("t3_done_count", done_seen - d0, 1);
      check("t3_busy_cycles", busy_seen - b0, 6);
      check("t3_sb_empty", sb.size(), 0);

      // 4. Two full-period bursts against the reference LFSR; a stray start
      //    mid-burst must not restart or shorten the first one.
      x0 = xnor_mism; d0 = done_seen; b0 = busy_seen;
      for (int k = 0; k < 2; k++) begin
         r = 7'h7F;
         for (int i = 0; i < 127; i++) begin
            push(r[6], r[6]);
            r = {r[5:0], r[6] ^ r[5]};
         end
      end
      start_burst(16'd127);
      repeat (9) step();
      start = 1'b1; len = 16'd5;
      step();
      start = 1'b0; len = '0;
      wait_done("t4_done_a", 300);
      check("t4_sb_after_a", sb.size(), 127);
      start_burst(16'd127);
      wait_done("t4_done_b", 300);
      check("t4_sb_empty", sb.size(), 0);
      check("t4_busy_cycles", busy_seen - b0, 254);
      check("t4_done_count", done_seen - d0, 2);
      check("t4_mismatches", xnor_mism - x0, 0);

      // 5. Error injected ahead of bit 4: only bit 4 flips.
      bits8 = 8'b1111_1110;
      for (int i = 7; i >= 0; i--) push((i == 4) ? ~bits8[i] : bits8[i], bits8[i]);
      x0 = xnor_mism;
      start_burst(16'd8);      // bit 1 on the link now
      step();                  // bit 2
      step();                  // bit 3
      inject_err = 1'b1;
      step();                  // bit 4, error pending
      inject_err = 1'b0;
      wait_done("t5_done", 20);
      check("t5_sb_empty", sb.size(), 0);
      check("t5_mismatches", xnor_mism - x0, 1);

      // 6a. len=0: done on the next cycle, O_valid never rises.
      v0 = valid_seen; d0 = done_seen;
      start_burst(16'd0);
      check("t6_len0_done", int'(done), 1);
      step();
      check("t6_len0_done_low", int'(done), 0);
      step();
      check("t6_len0_no_valid", valid_seen - v0, 0);
      check("t6_len0_done_count", done_seen - d0, 1);

      // 6b. Reset while bit 5 is on the link: IDLE at once, no done pulse.
      for (int i = 0; i < 4; i++) push(1'b1, 1'b1);
      d0 = done_seen;
      start_burst(16'd8);      // bit 1
      step();                  // bit 2
      step();                  // bit 3
      step();                  // bit 4
      step();                  // bit 5 presented
      ASYNCRESETN = 1'b0;
      #1;
      check("t6_rst_valid", int'(tx_if.O_valid), 0);
      check("t6_rst_busy", int'(busy), 0);
      check("t6_rst_O", int'(tx_if.O), 0);
      step();
      step();
      ASYNCRESETN = 1'b1;
      repeat (4) step();
      check("t6_no_done", done_seen - d0, 0);
      check("t6_idle_busy", int'(busy), 0);
      check("t6_sb_empty", sb.size(), 0);

      // 7. Pending error is cleared by reset.
      inject_err = 1'b1;
      step();
      inject_err = 1'b0;
      ASYNCRESETN = 1'b0;
      step();
      ASYNCRESETN = 1'b1;
      step();
      push(1'b1, 1'b1);
      x0 = xnor_mism;
      start_burst(16'd1);
      wait_done("t7_done", 10);
      check("t7_mismatches", xnor_mism - x0, 0);

      // 8. Repeated pulses in IDLE carry into the next burst and flip one bit.
      inject_err = 1'b1;
      repeat (3) step();
      inject_err = 1'b0;
      step();
      push(1'b0, 1'b1); push(1'b1, 1'b1);
      x0 = xnor_mism;
      start_burst(16'd2);
      wait_done("t8_done", 10);
      check("t8_mismatches", xnor_mism - x0, 1);
      check("final_sb_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_prbs_bit_tx
